// File: rtl/compare_result_collector.sv
// compare_result_collector: collects a window of comparator results and reports
// how many were greater / equal / less, plus whether any result was not one-hot.
module compare_result_collector #(
    parameter int unsigned WINDOW = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       A_greater,
    input  logic       A_equal,
    input  logic       A_less,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] gt_count,
    output logic [3:0] eq_count,
    output logic [3:0] lt_count,
    output logic       flag_err
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic {
        ACCUM  = 1'b0,
        REPORT = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;
    logic [2:0]       flags;
    logic             last_sample;

    // Flags gathered as {greater, equal, less} so one-hot decoding is a single case.
    assign flags = {A_greater, A_equal, A_less};

    // The accept that makes sample_cnt reach WINDOW closes the window.
    assign last_sample = (sample_cnt == CNT_W'(WINDOW - 1));

    // Window FSM: accumulate in ACCUM, hold the report in REPORT until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ACCUM;
            sample_cnt <= '0;
            gt_count   <= '0;
            eq_count   <= '0;
            lt_count   <= '0;
            flag_err   <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        sample_cnt <= sample_cnt + CNT_W'(1);
                        case (flags)
                            3'b100:  gt_count <= gt_count + CNT_W'(1);
                            3'b010:  eq_count <= eq_count + CNT_W'(1);
                            3'b001:  lt_count <= lt_count + CNT_W'(1);
                            default: flag_err <= 1'b1;
                        endcase
                        if (last_sample) begin
                            state     <= REPORT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                REPORT: begin
                    // No accept here: in_ready is low for the whole handshake cycle.
                    if (out_ready) begin
                        state      <= ACCUM;
                        sample_cnt <= '0;
                        gt_count   <= '0;
                        eq_count   <= '0;
                        lt_count   <= '0;
                        flag_err   <= 1'b0;
                        in_ready   <= 1'b1;
                        out_valid  <= 1'b0;
                    end
                end
                default: begin
                    state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_compare_result_collector.sv
// Testbench for compare_result_collector: four instances (WINDOW 8, 4, 2, 15)
// checked every cycle against a sample-list reference model.
module tb_compare_result_collector;

    localparam int NI = 4;
    localparam logic [2:0] FG = 3'b100;
    localparam logic [2:0] FE = 3'b010;
    localparam logic [2:0] FL = 3'b001;

    logic clk;
    logic rst;
    logic iv   [NI];
    logic ir   [NI];
    logic ag   [NI];
    logic ae   [NI];
    logic al   [NI];
    logic ov   [NI];
    logic ordy [NI];
    logic [3:0] gtc [NI];
    logic [3:0] eqc [NI];
    logic [3:0] ltc [NI];
    logic ferr [NI];

    for (genvar k = 0; k < NI; k++) begin : g_dut
        localparam int unsigned W = (k == 0) ? 8 : (k == 1) ? 4 : (k == 2) ? 2 : 15;
        compare_result_collector #(.WINDOW(W)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[k]),
            .in_ready  (ir[k]),
            .A_greater (ag[k]),
            .A_equal   (ae[k]),
            .A_less    (al[k]),
            .out_valid (ov[k]),
            .out_ready (ordy[k]),
            .gt_count  (gtc[k]),
            .eq_count  (eqc[k]),
            .lt_count  (ltc[k]),
            .flag_err  (ferr[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: the list of samples accepted into the current window.
    logic [2:0] smp [NI][16];
    int         n_s [NI];
    bit         rep [NI];

    function automatic int win_of(int i);
        case (i)
            0:       return 8;
            1:       return 4;
            2:       return 2;
            default: return 15;
        endcase
    endfunction

    function automatic int count_of(int i, logic [2:0] pat);
        int c = 0;
        for (int j = 0; j < n_s[i]; j++) if (smp[i][j] == pat) c++;
        return c;
    endfunction

    function automatic bit err_of(int i);
        for (int j = 0; j < n_s[i]; j++)
            if (smp[i][j] != FG && smp[i][j] != FE && smp[i][j] != FL) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            n_s[i] = 0;
            rep[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (rep[i]) begin
                if (ordy[i]) begin
                    n_s[i] = 0;
                    rep[i] = 1'b0;
                end
            end else if (iv[i]) begin
                smp[i][n_s[i]] = {ag[i], ae[i], al[i]};
                n_s[i]++;
                if (n_s[i] == win_of(i)) rep[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("in_ready[%0d]", i),  int'(ir[i]),   int'(!rep[i]));
            check($sformatf("out_valid[%0d]", i), int'(ov[i]),   int'(rep[i]));
            check($sformatf("gt_count[%0d]", i),  int'(gtc[i]),  count_of(i, FG));
            check($sformatf("eq_count[%0d]", i),  int'(eqc[i]),  count_of(i, FE));
            check($sformatf("lt_count[%0d]", i),  int'(ltc[i]),  count_of(i, FL));
            check($sformatf("flag_err[%0d]", i),  int'(ferr[i]), int'(err_of(i)));
        end
    endtask

    // One clock: inputs set by caller are applied at negedge, checked after posedge.
    task automatic step();
        @(negedge clk);
        if (rst) begin
            #1;
            model_reset();
            check_all();
        end
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all();
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            iv[i] = 1'b0; ag[i] = 1'b0; ae[i] = 1'b0; al[i] = 1'b0; ordy[i] = 1'b1;
        end
    endtask

    task automatic put(input int i, input logic [2:0] f);
        iv[i] = 1'b1;
        {ag[i], ae[i], al[i]} = f;
        step();
        iv[i] = 1'b0;
    endtask

    logic [2:0] seq8 [8];
    logic [2:0] seq4 [4];

    initial begin
        rst = 1'b1;
        idle_all();
        model_reset();
        step();
        step();
        check("reset in_ready", int'(ir[0]), 1);
        check("reset out_valid", int'(ov[0]), 0);
        rst = 1'b0;
        step();

        // Mixed window of 8, out_ready high.
        seq8 = '{FG, FG, FE, FL, FL, FL, FG, FE};
        for (int j = 0; j < 8; j++) put(0, seq8[j]);
        check("w8 out_valid", int'(ov[0]), 1);
        check("w8 gt", int'(gtc[0]), 3);
        check("w8 eq", int'(eqc[0]), 2);
        check("w8 lt", int'(ltc[0]), 3);
        check("w8 err", int'(ferr[0]), 0);
        step();
        check("w8 back to accum", int'(ir[0]), 1);

        // Window of 4 with two malformed samples.
        seq4 = '{3'b000, FG, 3'b110, FL};
        for (int j = 0; j < 4; j++) put(1, seq4[j]);
        check("w4 gt", int'(gtc[1]), 1);
        check("w4 eq", int'(eqc[1]), 0);
        check("w4 lt", int'(ltc[1]), 1);
        check("w4 err", int'(ferr[1]), 1);
        step();

        // Back-pressure: hold report for 10 cycles while upstream keeps offering.
        for (int j = 0; j < 8; j++) put(0, FE);
        ordy[0] = 1'b0;
        iv[0] = 1'b1;
        {ag[0], ae[0], al[0]} = FG;
        for (int j = 0; j < 10; j++) step();
        check("bp in_ready", int'(ir[0]), 0);
        check("bp eq held", int'(eqc[0]), 8);
        check("bp gt held", int'(gtc[0]), 0);
        ordy[0] = 1'b1;
        iv[0] = 1'b0;
        step();
        check("bp released", int'(ov[0]), 0);
        check("bp cleared", int'(eqc[0]), 0);

        // Gapped valid into window of 2.
        put(2, FE);
        step();
        check("gap no report yet", int'(ov[2]), 0);
        put(2, FE);
        check("gap report", int'(ov[2]), 1);
        check("gap eq", int'(eqc[2]), 2);
        step();

        // Reset mid-window discards partial counts.
        for (int j = 0; j < 5; j++) put(0, FG);
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int j = 0; j < 8; j++) put(0, FL);
        check("rst lt", int'(ltc[0]), 8);
        check("rst gt", int'(gtc[0]), 0);
        check("rst valid", int'(ov[0]), 1);
        step();

        // Maximum window.
        for (int j = 0; j < 15; j++) put(3, FG);
        check("w15 gt", int'(gtc[3]), 15);
        check("w15 valid", int'(ov[3]), 1);
        step();

        // Random traffic on all instances.
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NI; i++) begin
                logic [2:0] f;
                iv[i]   = ($urandom_range(0, 3) != 0);
                ordy[i] = ($urandom_range(0, 2) != 0);
                case ($urandom_range(0, 7))
                    0:       f = 3'($urandom_range(0, 7));
                    1, 2:    f = FG;
                    3, 4:    f = FE;
                    default: f = FL;
                endcase
                {ag[i], ae[i], al[i]} = f;
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        idle_all();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
